// File: rtl/elevator_request_debouncer.sv
// Per-button synchroniser, debouncer and sticky request latch for an
// elevator controller: hall up/down and car buttons, one channel each.
module elevator_request_debouncer #(
    parameter int FLOOR           = 6,
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FLOOR-1:0] outsideUp,
    input  logic [FLOOR-1:0] outsideDown,
    input  logic [FLOOR-1:0] insideFloor,
    input  logic [FLOOR-1:0] clrUp,
    input  logic [FLOOR-1:0] clrDown,
    input  logic [FLOOR-1:0] clrInside,
    output logic [FLOOR-1:0] queueUp,
    output logic [FLOOR-1:0] queueDown,
    output logic [FLOOR-1:0] queueinside,
    output logic             anyRequest
);

    localparam int N  = 3 * FLOOR;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    // No up call from the top floor, no down call from the ground floor.
    localparam logic [FLOOR-1:0] UP_OK   = ~(FLOOR'(1) << (FLOOR - 1));
    localparam logic [FLOOR-1:0] DOWN_OK = ~FLOOR'(1);
    localparam logic [N-1:0]     ALLOW   = {{FLOOR{1'b1}}, DOWN_OK, UP_OK};

    logic [N-1:0]  raw;
    logic [N-1:0]  clr;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  stable;
    logic [N-1:0]  pend;
    logic [N-1:0]  accept;
    logic [CW-1:0] cnt [N];

    assign raw = {insideFloor, outsideDown, outsideUp};
    assign clr = {clrInside, clrDown, clrUp};

    always_comb begin
        accept = '0;
        for (int i = 0; i < N; i++) begin
            accept[i] = sync2[i] & ~stable[i] & (cnt[i] == CMAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            pend   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CMAX) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                end
                // A press accepted on the same edge as a clear wins.
                if (accept[i] && ALLOW[i]) begin
                    pend[i] <= 1'b1;
                end else if (clr[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign queueUp     = pend[FLOOR-1:0];
    assign queueDown   = pend[2*FLOOR-1:FLOOR];
    assign queueinside = pend[N-1:2*FLOOR];
    assign anyRequest  = |pend;

endmodule

// File: tb/tb_elevator_request_debouncer.sv
// Scoreboard bench: stimulus queues expected queue snapshots tagged with
// the clock edge they belong to; the monitor compares them on negedge.
module tb_elevator_request_debouncer;

    localparam int F = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [F-1:0] outsideUp, outsideDown, insideFloor;
    logic [F-1:0] clrUp, clrDown, clrInside;
    logic [F-1:0] queueUp, queueDown, queueinside;
    logic         anyRequest;

    elevator_request_debouncer #(.FLOOR(F), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .outsideUp(outsideUp), .outsideDown(outsideDown),
        .insideFloor(insideFloor),
        .clrUp(clrUp), .clrDown(clrDown), .clrInside(clrInside),
        .queueUp(queueUp), .queueDown(queueDown),
        .queueinside(queueinside), .anyRequest(anyRequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        name;
        logic [F-1:0] qu;
        logic [F-1:0] qd;
        logic [F-1:0] qi;
        logic         any;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every entry due at this edge; a stale one is a miss.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc != cyc || queueUp !== e.qu || queueDown !== e.qd ||
                queueinside !== e.qi || anyRequest !== e.any) begin
                fails++;
                $display("FAIL %s edge=%0d got up=%b dn=%b in=%b any=%b exp up=%b dn=%b in=%b any=%b",
                         e.name, e.cyc, queueUp, queueDown, queueinside,
                         anyRequest, e.qu, e.qd, e.qi, e.any);
            end
        end
    end

    task automatic expect_at(input int k, input string nm, input logic [F-1:0] u,
                             input logic [F-1:0] d, input logic [F-1:0] i,
                             input logic a);
        exp_t e;
        e.cyc  = cyc + k;
        e.name = nm;
        e.qu   = u;
        e.qd   = d;
        e.qi   = i;
        e.any  = a;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        outsideUp = '0; outsideDown = '0; insideFloor = '0;
        clrUp = '0; clrDown = '0; clrInside = '0;
        step(2);
        expect_at(0, "reset", '0, '0, '0, 1'b0);
        step(1);

        // Latency: held car button latches after edge 6, not edge 5.
        rst = 1'b0;
        insideFloor = 6'b000100;
        expect_at(5, "lat_e5", '0, '0, '0, 1'b0);
        expect_at(6, "lat_e6", '0, '0, 6'b000100, 1'b1);
        step(6);
        insideFloor = '0;
        expect_at(10, "sticky", '0, '0, 6'b000100, 1'b1);
        step(10);

        // Three-cycle glitch is rejected.
        outsideUp = 6'b000010;
        step(3);
        outsideUp = '0;
        for (int k = 1; k <= 20; k += 4)
            expect_at(k, "glitch", '0, '0, 6'b000100, 1'b1);
        step(20);

        clrInside = 6'b000100;
        expect_at(1, "clr_in2", '0, '0, '0, 1'b0);
        step(1);
        clrInside = '0;

        // Down call latched, released, then cleared.
        outsideDown = 6'b001000;
        expect_at(6, "dn3_set", '0, 6'b001000, '0, 1'b1);
        step(6);
        outsideDown = '0;
        step(8);
        clrDown = 6'b001000;
        expect_at(1, "dn3_clr", '0, '0, '0, 1'b0);
        step(1);
        clrDown = 6'b111111;
        expect_at(1, "clr_idle", '0, '0, '0, 1'b0);
        step(1);
        clrDown = '0;

        // Forbidden directions never latch.
        outsideUp = 6'b100000;
        outsideDown = 6'b000001;
        expect_at(6, "forbid6", '0, '0, '0, 1'b0);
        expect_at(10, "forbid10", '0, '0, '0, 1'b0);
        step(10);
        outsideUp = '0;
        outsideDown = '0;
        step(8);

        // Many channels at once latch on the same edge.
        outsideUp = 6'b000001;
        outsideDown = 6'b100000;
        insideFloor = 6'b111111;
        expect_at(5, "multi_e5", '0, '0, '0, 1'b0);
        expect_at(6, "multi_e6", 6'b000001, 6'b100000, 6'b111111, 1'b1);
        step(6);
        outsideUp = '0;
        outsideDown = '0;
        insideFloor = '0;
        step(8);
        clrUp = '1; clrDown = '1; clrInside = '1;
        expect_at(1, "clr_all", '0, '0, '0, 1'b0);
        step(1);
        clrUp = '0; clrDown = '0; clrInside = '0;

        // Set wins over a clear on the accept edge; held button stays clear.
        insideFloor = 6'b000010;
        step(5);
        clrInside = 6'b000010;
        expect_at(1, "set_wins", '0, '0, 6'b000010, 1'b1);
        step(1);
        clrInside = '0;
        step(3);
        clrInside = 6'b000010;
        expect_at(1, "held_clr", '0, '0, '0, 1'b0);
        step(1);
        clrInside = '0;
        expect_at(10, "no_reset", '0, '0, '0, 1'b0);
        step(10);
        insideFloor = '0;
        step(8);

        // Reset mid-debounce clears a latched bit and the partial count.
        insideFloor = 6'b010000;
        expect_at(6, "pre_rst", '0, '0, 6'b010000, 1'b1);
        step(6);
        insideFloor = '0;
        step(8);
        outsideUp = 6'b001000;
        step(4);
        rst = 1'b1;
        expect_at(0, "rst_now", '0, '0, '0, 1'b0);
        step(1);
        rst = 1'b0;
        expect_at(5, "rst_e5", '0, '0, '0, 1'b0);
        expect_at(6, "rst_e6", 6'b001000, '0, '0, 1'b1);
        step(8);
        outsideUp = '0;

        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elevator_request_debouncer.md
ELEVATOR_REQUEST_DEBOUNCER -- requirements
Module: elevator_request_debouncer

Interface
REQ-001 Parameter FLOOR, default 6: number of floors and width of every per-floor vector; legal range 2..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 200: number of consecutive clk cycles a synchronised button level must hold before acceptance; legal range 2..2^20.
REQ-003 Port clk  input  1  elevator base clock, all state on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port outsideUp  input  FLOOR  hall up buttons, raw, high = pressed, asynchronous to clk.
REQ-006 Port outsideDown  input  FLOOR  hall down buttons, raw, high = pressed.
REQ-007 Port insideFloor  input  FLOOR  car buttons, raw, high = pressed.
REQ-008 Port clrUp / clrDown / clrInside  input  FLOOR each  controller service-complete strobes, one bit per floor, synchronous to clk.
REQ-009 Port queueUp / queueDown / queueinside  output  FLOOR each  latched pending requests.
REQ-010 Port anyRequest  output  1  OR of all bits of the three queues.

Function
REQ-011 Each of the 3*FLOOR button bits SHALL be processed by an independent, identical channel: 2-flop synchroniser, debounce counter, stable-level register, request latch.
REQ-012 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter never exceeds DEBOUNCE_CYCLES-1.
REQ-013 Each cycle: sync2 == stable -> counter <= 0; sync2 != stable and counter < DEBOUNCE_CYCLES-1 -> counter <= counter+1; sync2 != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= sync2, counter <= 0.
REQ-014 Accepted press = the cycle in which stable transitions 0->1; release (1->0) SHALL NOT affect the queue.
REQ-015 Accepted press SHALL set the queue bit on the same edge that updates stable.
REQ-016 Latency: raw input high before edge 1 and held -> queue bit high after edge DEBOUNCE_CYCLES+2.
REQ-017 Any pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL be rejected (counter returns to 0, no queue change).
REQ-018 Queue bit SHALL stay set (sticky) after button release until its clr bit is sampled high.
REQ-019 clr bit high for one cycle SHALL clear the matching queue bit on that edge; clr on an already-clear bit has no effect.
REQ-020 Simultaneous accepted press and clr on the same bit: set wins, bit remains 1.
REQ-021 Held button SHALL NOT re-set a bit after clear; a new set requires release acceptance then press acceptance.
REQ-022 queueUp[FLOOR-1] and queueDown[0] SHALL be forced 0 permanently (no up call at top floor, no down call at ground).
REQ-023 Channels SHALL be fully independent; simultaneous presses on any number of bits each latch correctly.
REQ-024 anyRequest SHALL be combinational from queue registers (same cycle as queue change).

Reset
REQ-025 rst high SHALL immediately clear all sync flops, counters, stable registers and queues; all outputs 0.
REQ-026 Reset mid-debounce SHALL discard the partial count; after rst release a still-held button requires a full DEBOUNCE_CYCLES+2 cycles to latch.
REQ-027 rst deassertion is synchronised externally; block needs no reset-release sequencing.

Verification (FLOOR=6, DEBOUNCE_CYCLES=4)
REQ-028 Hold insideFloor[2]=1 from before edge 1 -> queueinside=6'b000100 and anyRequest=1 after edge 6, not after edge 5.
REQ-029 outsideUp[1] high for 3 cycles then low -> queueUp stays 0 for 20 cycles.
REQ-030 queueDown[3] latched, button released, clrDown[3] pulsed 1 cycle -> queueDown=0 next edge; anyRequest=0.
REQ-031 Press outsideUp[5] and outsideDown[0] held 10 cycles -> queueUp=0, queueDown=0; press outsideUp[0], outsideDown[5], insideFloor[0..5] together -> queueUp=6'b000001, queueDown=6'b100000, queueinside=6'b111111 on the same edge.
REQ-032 clrInside[1] asserted on exact edge insideFloor[1] press is accepted -> queueinside[1]=1; held button after a later clear -> no re-set.
REQ-033 rst pulsed after 2 counted cycles of held outsideUp[3] -> all outputs 0 immediately; queueUp[3] sets 6 edges after rst release.
